// File: rtl/heu_pkg.sv
// Shared constants and state encoding for the histogram-equalization unit.
package heu_pkg;
    localparam int PIX_W    = 8;
    localparam int BEAT_PIX = 80;
    localparam int WIN_PIX  = 400;
    localparam int BEATS    = WIN_PIX / BEAT_PIX;
    localparam int NBINS    = 2 ** PIX_W;
    localparam int CNT_W    = 9;
    localparam int HIST_W   = 9;
    localparam int BEAT_W   = 3;

    typedef enum logic [1:0] {
        LOAD,
        HIST,
        CDF,
        MAP
    } state_t;
endpackage

// File: rtl/heu_scale.sv
// Combinational CDF-to-pixel mapper: floor(cdf * 255 / 400).
module heu_scale
    import heu_pkg::*;
(
    input  logic [HIST_W-1:0] i_cdf,
    output logic [PIX_W-1:0]  o_pix
);
    // 400 * 255 = 102000 fits in 17 bits, and the quotient never exceeds 255.
    logic [16:0] w_prod;

    assign w_prod = 17'(i_cdf) * 17'd255;
    assign o_pix  = PIX_W'(w_prod / 17'd400);
endmodule

// File: rtl/heu.sv
// Histogram-equalization unit: load a 20x20 window, build histogram and CDF,
// then stream the equalized pixels in raster order.
module heu
    import heu_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             vldIpgu,
    input  logic [BEAT_PIX-1:0][PIX_W-1:0]   ipguOutBufferQ,
    output logic                             rdyHeu,
    output logic                             outVld,
    output logic [PIX_W-1:0]                 outPix,
    output logic                             outLast,
    input  logic                             outRdy,
    output logic                             busy
);
    state_t              r_state;
    state_t              w_state_next;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]    r_idx;
    logic [HIST_W-1:0]   r_run;

    logic [PIX_W-1:0]    r_buf [WIN_PIX];
    logic [HIST_W-1:0]   r_cdf [NBINS];
    logic [HIST_W-1:0]   w_hist_bins [NBINS];

    logic                w_beat_fire;
    logic                w_beat_last;
    logic                w_out_fire;
    logic                w_idx_last_win;
    logic                w_idx_last_bin;
    logic [CNT_W-1:0]    w_base;
    logic [PIX_W-1:0]    w_buf_pix;
    logic [PIX_W-1:0]    w_cur_bin;
    logic [HIST_W-1:0]   w_hist_cur;
    logic [PIX_W-1:0]    w_scaled;

    // Ready is a pure state decode; upstream drops valid on seeing ready.
    assign rdyHeu         = (r_state == LOAD);
    assign w_beat_fire    = rdyHeu && vldIpgu;
    assign w_beat_last    = (r_beat_cnt == BEAT_W'(BEATS - 1));
    assign w_out_fire     = outVld && outRdy;
    assign w_idx_last_win = (r_idx == CNT_W'(WIN_PIX - 1));
    assign w_idx_last_bin = (r_idx == CNT_W'(NBINS - 1));
    assign w_base         = CNT_W'(r_beat_cnt) * CNT_W'(BEAT_PIX);
    assign w_buf_pix      = r_buf[r_idx];
    assign w_cur_bin      = r_idx[PIX_W-1:0];
    assign w_hist_cur     = w_hist_bins[w_cur_bin];

    always_ff @(posedge clk) begin
        if (w_beat_fire) begin
            for (int j = 0; j < BEAT_PIX; j++) begin
                r_buf[w_base + CNT_W'(j)] <= ipguOutBufferQ[j];
            end
        end
    end

    // Each bin counts in HIST and is cleared as the CDF pass consumes it.
    generate
        for (genvar gi = 0; gi < NBINS; gi++) begin : g_bin
            logic [HIST_W-1:0] r_bin;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_bin <= '0;
                end else if (r_state == HIST && w_buf_pix == PIX_W'(gi)) begin
                    r_bin <= r_bin + HIST_W'(1);
                end else if (r_state == CDF && w_cur_bin == PIX_W'(gi)) begin
                    r_bin <= '0;
                end
            end

            assign w_hist_bins[gi] = r_bin;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (r_state == CDF) begin
            r_cdf[w_cur_bin] <= r_run + w_hist_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LOAD;
            r_beat_cnt <= '0;
            r_idx      <= '0;
            r_run      <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                LOAD: begin
                    r_idx <= '0;
                    r_run <= '0;
                    if (w_beat_fire) begin
                        r_beat_cnt <= w_beat_last ? '0 : r_beat_cnt + BEAT_W'(1);
                    end
                end
                HIST: r_idx <= w_idx_last_win ? '0 : r_idx + CNT_W'(1);
                CDF: begin
                    r_run <= r_run + w_hist_cur;
                    r_idx <= w_idx_last_bin ? '0 : r_idx + CNT_W'(1);
                end
                MAP: begin
                    if (w_out_fire) begin
                        r_idx <= w_idx_last_win ? '0 : r_idx + CNT_W'(1);
                    end
                end
                default: r_idx <= '0;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOAD: if (w_beat_fire && w_beat_last) w_state_next = HIST;
            HIST: if (w_idx_last_win) w_state_next = CDF;
            CDF:  if (w_idx_last_bin) w_state_next = MAP;
            MAP:  if (w_out_fire && w_idx_last_win) w_state_next = LOAD;
            default: w_state_next = LOAD;
        endcase
    end

    heu_scale u_scale (
        .i_cdf (r_cdf[w_buf_pix]),
        .o_pix (w_scaled)
    );

    // Output pixel and last flag are functions of k, so they hold while stalled.
    assign outVld  = (r_state == MAP);
    assign outPix  = outVld ? w_scaled : '0;
    assign outLast = outVld && w_idx_last_win;
    assign busy    = !((r_state == LOAD) && (r_beat_cnt == '0));
endmodule

// File: tb/tb_heu.sv
// Directed bench for heu: constant, ramp, stalls, backpressure and resets.
module tb_heu;
    logic                clk;
    logic                rst;
    logic                vldIpgu;
    logic [79:0][7:0]    ipguOutBufferQ;
    logic                rdyHeu;
    logic                outVld;
    logic [7:0]          outPix;
    logic                outLast;
    logic                outRdy;
    logic                busy;

    int n_checks;
    int n_fail;
    logic [7:0] win [400];
    int exp_out [400];

    heu dut (
        .clk            (clk),
        .rst            (rst),
        .vldIpgu        (vldIpgu),
        .ipguOutBufferQ (ipguOutBufferQ),
        .rdyHeu         (rdyHeu),
        .outVld         (outVld),
        .outPix         (outPix),
        .outLast        (outLast),
        .outRdy         (outRdy),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic fill_const(input int v);
        for (int n = 0; n < 400; n++) win[n] = 8'(v);
    endtask

    task automatic fill_ramp();
        for (int n = 0; n < 400; n++) win[n] = 8'(n % 200);
    endtask

    // Reference: histogram, running sum, then floor(cdf*255/400) per pixel.
    task automatic build_expected();
        int h [256];
        int c [256];
        int acc;
        for (int b = 0; b < 256; b++) h[b] = 0;
        for (int n = 0; n < 400; n++) h[win[n]]++;
        acc = 0;
        for (int b = 0; b < 256; b++) begin
            acc += h[b];
            c[b] = acc;
        end
        for (int n = 0; n < 400; n++) exp_out[n] = (c[win[n]] * 255) / 400;
    endtask

    task automatic send_window(input int gap, input bit hold_vld);
        int t;
        for (int b = 0; b < 5; b++) begin
            for (int j = 0; j < 80; j++) ipguOutBufferQ[j] = win[b * 80 + j];
            vldIpgu = 1'b1;
            t = 0;
            while (!rdyHeu && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("rdy_before_beat", 32'(rdyHeu), 32'd1);
            @(posedge clk);
            @(negedge clk);
            if (b == 0) chk("busy_mid_load", 32'(busy), 32'd1);
            if (b < 4) begin
                if (gap > 0) begin
                    vldIpgu = 1'b0;
                    for (int j = 0; j < 80; j++) ipguOutBufferQ[j] = 8'hAA;
                    repeat (gap) @(negedge clk);
                end
            end else begin
                for (int j = 0; j < 80; j++) ipguOutBufferQ[j] = 8'hFF;
                vldIpgu = hold_vld;
            end
        end
        chk("rdy_low_after_load", 32'(rdyHeu), 32'd0);
        chk("busy_after_load", 32'(busy), 32'd1);
    endtask

    // Called on the negedge right after the last beat was accepted.
    task automatic collect(input bit backpressure, input int max_hs, input bit is_ramp);
        int n;
        int hs;
        int cyc;
        bit r;
        bit prev_stall;
        logic [7:0] prev_pix;
        logic prev_last;
        bit pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        n = 0;
        while (!outVld && n < 2000) begin
            if (n == 300) begin
                chk("busy_in_hist", 32'(busy), 32'd1);
                chk("rdy_in_hist", 32'(rdyHeu), 32'd0);
            end
            @(negedge clk);
            n++;
        end
        chk("first_out_latency", 32'(n), 32'd656);
        vldIpgu = 1'b0;
        hs = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_pix = '0;
        prev_last = 1'b0;
        while (hs < max_hs && cyc < 5000) begin
            r = backpressure ? pat[cyc % 4] : 1'b1;
            outRdy = r;
            chk("out_vld", 32'(outVld), 32'd1);
            chk("out_pix", 32'(outPix), 32'(exp_out[hs]));
            chk("out_last", 32'(outLast), 32'(hs == 399));
            if (prev_stall) begin
                chk("hold_pix", 32'(outPix), 32'(prev_pix));
                chk("hold_last", 32'(outLast), 32'(prev_last));
            end
            if (is_ramp && win[hs] == 8'd0)   chk("ramp_in0", 32'(outPix), 32'd1);
            if (is_ramp && win[hs] == 8'd99)  chk("ramp_in99", 32'(outPix), 32'd127);
            if (is_ramp && win[hs] == 8'd199) chk("ramp_in199", 32'(outPix), 32'd255);
            prev_pix = outPix;
            prev_last = outLast;
            prev_stall = !r;
            if (r) hs++;
            cyc++;
            @(negedge clk);
        end
        outRdy = 1'b1;
        chk("handshake_count", 32'(hs), 32'(max_hs));
        if (max_hs == 400) begin
            chk("rdy_after_drain", 32'(rdyHeu), 32'd1);
            chk("vld_after_drain", 32'(outVld), 32'd0);
            chk("last_after_drain", 32'(outLast), 32'd0);
            chk("busy_after_drain", 32'(busy), 32'd0);
        end
        $display("window done: %0d handshakes in %0d cycles, latency %0d", hs, cyc, n);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({tag, "_rdy"}, 32'(rdyHeu), 32'd1);
        chk({tag, "_vld"}, 32'(outVld), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_last"}, 32'(outLast), 32'd0);
        $display("reset pulse applied: %s", tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        vldIpgu = 1'b0;
        outRdy = 1'b1;
        for (int j = 0; j < 80; j++) ipguOutBufferQ[j] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_rdy", 32'(rdyHeu), 32'd1);
        chk("reset_vld", 32'(outVld), 32'd0);
        chk("reset_last", 32'(outLast), 32'd0);
        chk("reset_pix", 32'(outPix), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Constant 37 window, no stalls.
        fill_const(37);
        build_expected();
        send_window(0, 1'b0);
        collect(1'b0, 400, 1'b0);

        // Ramp right after: upstream gaps, valid held high outside LOAD, backpressure.
        fill_ramp();
        build_expected();
        send_window(3, 1'b1);
        collect(1'b1, 400, 1'b1);

        // Ramp again, no stalls.
        send_window(0, 1'b0);
        collect(1'b0, 400, 1'b1);

        // Reset in HIST.
        fill_const(37);
        build_expected();
        send_window(0, 1'b0);
        repeat (100) @(negedge clk);
        pulse_reset("rst_hist");

        // Ramp partially drained, then reset in MAP.
        fill_ramp();
        build_expected();
        send_window(0, 1'b0);
        collect(1'b0, 10, 1'b1);
        pulse_reset("rst_map");

        // Constant 37 after the resets still maps to 255.
        fill_const(37);
        build_expected();
        send_window(0, 1'b0);
        collect(1'b0, 400, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/heu.md
Name: heu

Overview:
- Histogram-equalization unit directly downstream of the image-pyramid generator.
- Accepts one 20x20 window of 8-bit pixels as five 80-pixel beats over the vldIpgu/rdyHeu handshake.
- Builds the 256-bin histogram and its cumulative distribution, then streams 400 equalized pixels in raster order to the next stage over a valid/ready handshake.
- Processes one window at a time; the next window is accepted only after the previous window has fully drained.

Parameters:
- PIX_W, 8, pixel width in bits; the bin count is 2**PIX_W = 256.
- BEAT_PIX, 80, pixels per input beat.
- WIN_PIX, 400, pixels per window; BEATS = WIN_PIX/BEAT_PIX = 5.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- vldIpgu  in  1  upstream beat valid.
- ipguOutBufferQ  in  [PIX_W-1:0] x [BEAT_PIX-1:0]  beat data; element 0 is the earliest pixel.
- rdyHeu  out  1  ready for a beat.
- outVld  out  1  equalized pixel valid.
- outPix  out  PIX_W  equalized pixel.
- outLast  out  1  marks pixel 399 of the window.
- outRdy  in  1  downstream ready.
- busy  out  1  high in any state other than LOAD with beatCnt==0.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - State = LOAD, beatCnt = 0, all counters = 0.
  - All 256 histogram bins = 0.
  - rdyHeu = 1, outVld = 0, outLast = 0, outPix = 0, busy = 0.
- Reset mid-operation: aborts the current window immediately with no output. The next cycle restarts in LOAD.
- Storage:
  - Window buffer: 400 x PIX_W.
  - hist: 256 x 9-bit.
  - cdf: 256 x 9-bit.
- LOAD state:
  - rdyHeu = 1.
  - rdyHeu is decoded from state only and must never depend combinationally on vldIpgu, because upstream drops valid in the same cycle it sees ready.
  - A beat is accepted when vldIpgu && rdyHeu. Element j is written to buffer[beatCnt*80 + j], then beatCnt increments.
  - When the 5th beat is accepted: beatCnt -> 0 and next state is HIST.
  - rdyHeu = 0 in every other state; vldIpgu is ignored there.
- HIST state, 400 cycles:
  - Index i runs 0..399; each cycle performs hist[buffer[i]] += 1.
  - One update per cycle, so no read-modify-write hazard.
  - After i = 399, go to CDF.
- CDF state, 256 cycles:
  - Bin b runs 0..255.
  - run = run + hist[b]; cdf[b] = run.
  - hist[b] is cleared to 0 in the same cycle, so the next window starts with an empty histogram.
  - run is 9-bit; its maximum is 400, so no overflow.
  - After b = 255, go to MAP.
- MAP state:
  - outVld = 1.
  - outPix = (cdf[buffer[k]] * 255) / 400, using a 17-bit product, truncating division by the constant, result <= 255.
  - k increments on outVld && outRdy.
  - outLast = (k == 399).
  - When outRdy = 0: outPix, outLast and k hold.
  - The handshake on k = 399 returns to LOAD, clears k, and deasserts outVld.
- Latency: minimum 5 + 400 + 256 + 400 = 1061 cycles per window with no backpressure.
  - First output appears 656 cycles after the last beat is accepted.
- Total-window invariant: cdf[255] == 400 always, so the brightest present level maps to 255.

Decomposition:
- Shared package heu_pkg:
  - state_t enum {LOAD, HIST, CDF, MAP}.
  - Constants WIN_PIX, BEAT_PIX, BEATS, NBINS = 256.
- Natural sub-module: heu_scale, the combinational cdf*255/400 mapper. It can be reused and tested standalone.
- The histogram/CDF arrays stay inline.

Test Plan:
- Constant window, all pixels = 37 -> cdf[b] = 0 for b < 37 and 400 for b >= 37.
  - All 400 outputs = 255, outLast only on the 400th pixel.
  - rdyHeu reasserts the cycle after the final handshake.
- Ramp window, pixel n = n mod 200 (each value appears twice):
  - Input 0 -> output 1; input 99 -> output 127; input 199 -> output 255.
  - Output order matches input raster order.
- Backpressure: outRdy toggles 1,0,0,1 repeatedly.
  - outPix and outLast hold while outRdy = 0.
  - Exactly 400 handshakes occur; no pixel is duplicated or dropped.
- Upstream stalls: vldIpgu gaps of 3 cycles between beats -> beats land at the correct offsets.
  - With vldIpgu held high outside LOAD, no extra beat is accepted.
- Back-to-back windows: constant 37, then ramp.
  - The second window's outputs equal the isolated-ramp results, which proves the histogram was cleared.
- Reset asserted for 1 cycle in HIST, then in MAP:
  - State returns to LOAD, outVld = 0, rdyHeu = 1.
  - A subsequent constant-37 window still yields 255s.
